// File: rtl/traffic_sched.sv
// traffic_sched: phase scheduler for a two-axis (NS/EW) signalised intersection.
// Divides clk into ticks and runs the car sequence G -> Y1 -> L -> Y2 -> AR,
// alternating between the two axes. It latches pedestrian requests, grants
// walk windows with a flashing clearance, and handles emergency preemption.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   i_enable     run; low forces IDLE
//   i_ped_req    [0] cross NS road, [1] cross EW road (pulse or level)
//   i_emg_req    emergency preemption request (level)
//   i_emg_dir    axis to clear for the emergency: 0=NS, 1=EW
//   o_phase      current state code
//   o_tick       one-cycle tick strobe
//   o_ns_car     NS car head  (RED 1000, YELLOW 0100, LEFT 0010, GREEN 0001)
//   o_ew_car     EW car head
//   o_ns_walk    walk head for crossing the NS road (RED 10, GREEN 01)
//   o_ew_walk    walk head for crossing the EW road
//   o_ped_pend   latched pending pedestrian requests
module traffic_sched #(
  parameter int TICK_DIV = 100,
  parameter int T_GREEN  = 20,
  parameter int T_YELLOW = 2,
  parameter int T_LEFT   = 10,
  parameter int T_ALLRED = 1,
  parameter int T_WALK   = 14,
  parameter int T_FLASH  = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_enable,
  input  logic [1:0] i_ped_req,
  input  logic       i_emg_req,
  input  logic       i_emg_dir,
  output logic [3:0] o_phase,
  output logic       o_tick,
  output logic [3:0] o_ns_car,
  output logic [3:0] o_ew_car,
  output logic [1:0] o_ns_walk,
  output logic [1:0] o_ew_walk,
  output logic [1:0] o_ped_pend
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    NS_G  = 4'd1,
    NS_Y1 = 4'd2,
    NS_L  = 4'd3,
    NS_Y2 = 4'd4,
    AR_A  = 4'd5,
    EW_G  = 4'd6,
    EW_Y1 = 4'd7,
    EW_L  = 4'd8,
    EW_Y2 = 4'd9,
    AR_B  = 4'd10,
    EMG   = 4'd11
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = 16;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  localparam logic [3:0] CAR_RED    = 4'b1000;
  localparam logic [3:0] CAR_YELLOW = 4'b0100;
  localparam logic [3:0] CAR_LEFT   = 4'b0010;
  localparam logic [3:0] CAR_GREEN  = 4'b0001;
  localparam logic [3:0] CAR_NONE   = 4'b0000;

  localparam logic [1:0] W_RED   = 2'b10;
  localparam logic [1:0] W_GREEN = 2'b01;
  localparam logic [1:0] W_NONE  = 2'b00;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   presc;
  logic [TW-1:0]   ptick;
  logic            tick_done;
  logic            phase_end;
  logic            emg_act;
  logic            emg_dir;
  logic            emg_dir_eff;
  logic [1:0]      pend;
  logic            ns_walk_act;
  logic            ew_walk_act;
  logic            ns_win_start;
  logic            ew_win_start;

  // Index of the final tick of each timed phase.
  function automatic logic [TW-1:0] last_tick(input state_t s);
    case (s)
      NS_G, EW_G:                 last_tick = TW'(T_GREEN - 1);
      NS_Y1, NS_Y2, EW_Y1, EW_Y2: last_tick = TW'(T_YELLOW - 1);
      NS_L, EW_L:                 last_tick = TW'(T_LEFT - 1);
      AR_A, AR_B:                 last_tick = TW'(T_ALLRED - 1);
      default:                    last_tick = '0;
    endcase
  endfunction

  // Walk head inside an active window, by tick index from phase entry.
  function automatic logic [1:0] walk_head(input logic [TW-1:0] n);
    logic [TW-1:0] k;
    k = n - TW'(T_WALK);
    if (n < TW'(T_WALK))
      walk_head = W_GREEN;
    else if (k < TW'(T_FLASH))
      walk_head = k[0] ? W_NONE : W_GREEN;
    else
      walk_head = W_RED;
  endfunction

  assign tick_done = (state != IDLE) && (presc == PRESC_LAST);
  assign phase_end = tick_done && (ptick == last_tick(state));

  // The first sampled edge of a request acts on the live direction; after
  // that the latched direction is used.
  assign emg_dir_eff = emg_act ? emg_dir : i_emg_dir;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic; emergency checks precede end-of-phase so they win.
  always_comb begin
    state_nxt = state;
    if (!i_enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  state_nxt = NS_G;
        NS_G: begin
          if (i_emg_req)      state_nxt = emg_dir_eff ? NS_Y2 : EMG;
          else if (phase_end) state_nxt = NS_Y1;
        end
        NS_Y1: if (phase_end) state_nxt = i_emg_req ? AR_A : NS_L;
        NS_L: begin
          if (i_emg_req)      state_nxt = emg_dir_eff ? NS_Y2 : EMG;
          else if (phase_end) state_nxt = NS_Y2;
        end
        NS_Y2: if (phase_end) state_nxt = AR_A;
        AR_A:  if (phase_end) state_nxt = i_emg_req ? EMG : EW_G;
        EW_G: begin
          if (i_emg_req)      state_nxt = emg_dir_eff ? EMG : EW_Y2;
          else if (phase_end) state_nxt = EW_Y1;
        end
        EW_Y1: if (phase_end) state_nxt = i_emg_req ? AR_B : EW_L;
        EW_L: begin
          if (i_emg_req)      state_nxt = emg_dir_eff ? EMG : EW_Y2;
          else if (phase_end) state_nxt = EW_Y2;
        end
        EW_Y2: if (phase_end) state_nxt = AR_B;
        AR_B:  if (phase_end) state_nxt = i_emg_req ? EMG : NS_G;
        EMG:   if (!i_emg_req) state_nxt = emg_dir ? EW_Y2 : NS_Y2;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Prescaler and phase timer restart on every state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      ptick <= '0;
    end else if ((state_nxt != state) || (state == IDLE)) begin
      presc <= '0;
      ptick <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      ptick <= ptick + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Emergency latch: direction captured on the first high sample while running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      emg_act <= 1'b0;
      emg_dir <= 1'b0;
    end else if (!i_enable || (state == IDLE)) begin
      emg_act <= 1'b0;
    end else if (i_emg_req) begin
      emg_act <= 1'b1;
      if (!emg_act)
        emg_dir <= i_emg_dir;
    end else begin
      emg_act <= 1'b0;
    end
  end

  // A request on the window-start edge itself counts as served.
  assign ns_win_start = (state_nxt == EW_G) && (state != EW_G) &&
                        (pend[0] || i_ped_req[0]);
  assign ew_win_start = (state_nxt == NS_G) && (state != NS_G) &&
                        (pend[1] || i_ped_req[1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend        <= '0;
      ns_walk_act <= 1'b0;
      ew_walk_act <= 1'b0;
    end else begin
      pend[0] <= ns_win_start ? 1'b0 : (pend[0] | i_ped_req[0]);
      pend[1] <= ew_win_start ? 1'b0 : (pend[1] | i_ped_req[1]);
      // Window flags only matter in their G state; leaving it drops them.
      if (state_nxt != state) begin
        ns_walk_act <= ns_win_start;
        ew_walk_act <= ew_win_start;
      end
    end
  end

  // Output decode from registered state only.
  always_comb begin
    o_ns_car  = CAR_NONE;
    o_ew_car  = CAR_NONE;
    o_ns_walk = W_NONE;
    o_ew_walk = W_NONE;
    if (state != IDLE) begin
      o_ns_car  = CAR_RED;
      o_ew_car  = CAR_RED;
      o_ns_walk = W_RED;
      o_ew_walk = W_RED;
    end
    case (state)
      NS_G: begin
        o_ns_car = CAR_GREEN;
        if (ew_walk_act) o_ew_walk = walk_head(ptick);
      end
      NS_Y1, NS_Y2: o_ns_car = CAR_YELLOW;
      NS_L:         o_ns_car = CAR_LEFT;
      EW_G: begin
        o_ew_car = CAR_GREEN;
        if (ns_walk_act) o_ns_walk = walk_head(ptick);
      end
      EW_Y1, EW_Y2: o_ew_car = CAR_YELLOW;
      EW_L:         o_ew_car = CAR_LEFT;
      EMG: begin
        if (emg_dir) o_ew_car = CAR_GREEN;
        else         o_ns_car = CAR_GREEN;
      end
      default: ;
    endcase
  end

  assign o_phase    = state;
  assign o_tick     = tick_done;
  assign o_ped_pend = pend;

endmodule

// File: tb/tb_traffic_sched.sv
// Testbench for traffic_sched: directed stimulus with hand-computed expected
// head/phase values pushed into a scoreboard queue, checked by a monitor.
module tb_traffic_sched;

  localparam int TD = 4;
  localparam int C0 = 6;

  localparam logic [3:0] CR = 4'b1000;
  localparam logic [3:0] CY = 4'b0100;
  localparam logic [3:0] CL = 4'b0010;
  localparam logic [3:0] CG = 4'b0001;
  localparam logic [3:0] CN = 4'b0000;
  localparam logic [1:0] WR = 2'b10;
  localparam logic [1:0] WG = 2'b01;
  localparam logic [1:0] WN = 2'b00;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [1:0] ped_req;
  logic       emg_req;
  logic       emg_dir;
  logic [3:0] phase;
  logic       tick;
  logic [3:0] ns_car;
  logic [3:0] ew_car;
  logic [1:0] ns_walk;
  logic [1:0] ew_walk;
  logic [1:0] ped_pend;

  traffic_sched #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_enable   (enable),
    .i_ped_req  (ped_req),
    .i_emg_req  (emg_req),
    .i_emg_dir  (emg_dir),
    .o_phase    (phase),
    .o_tick     (tick),
    .o_ns_car   (ns_car),
    .o_ew_car   (ew_car),
    .o_ns_walk  (ns_walk),
    .o_ew_walk  (ew_walk),
    .o_ped_pend (ped_pend)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] ph;
    logic [3:0] nsc;
    logic [3:0] ewc;
    logic [1:0] nsw;
    logic [1:0] eww;
    logic [1:0] pd;
    logic       tk;
    bit         ctk;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int checks = 0;
  int failures = 0;

  // r is the edge count relative to the first enabled edge (r=1 -> NS_G).
  task automatic ex(input int r, input logic [3:0] ph, input logic [3:0] nsc,
                    input logic [3:0] ewc, input logic [1:0] nsw,
                    input logic [1:0] eww, input logic [1:0] pd, input int tk);
    exp_t e;
    e.cyc = C0 + r;
    e.ph  = ph;
    e.nsc = nsc;
    e.ewc = ewc;
    e.nsw = nsw;
    e.eww = eww;
    e.pd  = pd;
    e.ctk = (tk >= 0);
    e.tk  = (tk == 1);
    sb.push_back(e);
  endtask

  task automatic wait_r(input int r);
    while (cyc < C0 + r) @(negedge clk);
  endtask

  // Monitor: compares outputs at the negedge of the scheduled cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m = sb.pop_front();
      checks++;
      if (m.cyc < cyc) begin
        failures++;
        $display("FAIL missed_r=%0d got cycle=%0d required cycle=%0d", m.cyc - C0, cyc, m.cyc);
      end else if (!((phase === m.ph) && (ns_car === m.nsc) && (ew_car === m.ewc) &&
                     (ns_walk === m.nsw) && (ew_walk === m.eww) && (ped_pend === m.pd) &&
                     (!m.ctk || (tick === m.tk)))) begin
        failures++;
        $display("FAIL step_r=%0d got ph=%0d ns=%b ew=%b nsw=%b eww=%b pend=%b tick=%b required ph=%0d ns=%b ew=%b nsw=%b eww=%b pend=%b tick=%b(chk=%0d)",
                 m.cyc - C0, phase, ns_car, ew_car, ns_walk, ew_walk, ped_pend, tick,
                 m.ph, m.nsc, m.ewc, m.nsw, m.eww, m.pd, m.tk, m.ctk);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    ped_req = 2'b00;
    emg_req = 1'b0;
    emg_dir = 1'b0;

    // Reset and idle
    ex(-4, 4'd0, CN, CN, WN, WN, 2'b00, 0);
    ex(-1, 4'd0, CN, CN, WN, WN, 2'b00, 0);
    wait_r(-3);
    reset_n = 1'b1;
    wait_r(0);
    enable = 1'b1;

    // Normal cycle, NS-road walk served once, then a quiet round
    ex(1,   4'd1,  CG, CR, WR, WR, 2'b00, 0);
    ex(4,   4'd1,  CG, CR, WR, WR, 2'b00, 1);
    ex(5,   4'd1,  CG, CR, WR, WR, 2'b00, 0);
    ex(10,  4'd1,  CG, CR, WR, WR, 2'b01, -1);
    ex(80,  4'd1,  CG, CR, WR, WR, 2'b01, 1);
    ex(81,  4'd2,  CY, CR, WR, WR, 2'b01, 0);
    ex(89,  4'd3,  CL, CR, WR, WR, 2'b01, -1);
    ex(129, 4'd4,  CY, CR, WR, WR, 2'b01, -1);
    ex(137, 4'd5,  CR, CR, WR, WR, 2'b01, -1);
    ex(140, 4'd5,  CR, CR, WR, WR, 2'b01, 1);
    ex(141, 4'd6,  CR, CG, WG, WR, 2'b00, 0);
    ex(196, 4'd6,  CR, CG, WG, WR, 2'b00, -1);
    ex(197, 4'd6,  CR, CG, WG, WR, 2'b00, -1);
    ex(201, 4'd6,  CR, CG, WN, WR, 2'b00, -1);
    ex(205, 4'd6,  CR, CG, WG, WR, 2'b00, -1);
    ex(220, 4'd6,  CR, CG, WN, WR, 2'b00, -1);
    ex(221, 4'd7,  CR, CY, WR, WR, 2'b00, -1);
    ex(229, 4'd8,  CR, CL, WR, WR, 2'b00, -1);
    ex(269, 4'd9,  CR, CY, WR, WR, 2'b00, -1);
    ex(277, 4'd10, CR, CR, WR, WR, 2'b00, -1);
    ex(281, 4'd1,  CG, CR, WR, WR, 2'b00, -1);
    ex(300, 4'd1,  CG, CR, WR, WR, 2'b00, -1);
    ex(421, 4'd6,  CR, CG, WR, WR, 2'b00, -1);
    ex(561, 4'd1,  CG, CR, WR, WR, 2'b00, -1);
    wait_r(9);
    ped_req = 2'b01;
    wait_r(10);
    ped_req = 2'b00;

    // Emergency for EW raised in NS_G; direction change in EMG ignored
    ex(581, 4'd1,  CG, CR, WR, WR, 2'b00, -1);
    ex(582, 4'd4,  CY, CR, WR, WR, 2'b00, -1);
    ex(589, 4'd4,  CY, CR, WR, WR, 2'b00, -1);
    ex(590, 4'd5,  CR, CR, WR, WR, 2'b00, -1);
    ex(593, 4'd5,  CR, CR, WR, WR, 2'b00, 1);
    ex(594, 4'd11, CR, CG, WR, WR, 2'b00, -1);
    ex(620, 4'd11, CR, CG, WR, WR, 2'b00, -1);
    ex(621, 4'd9,  CR, CY, WR, WR, 2'b00, -1);
    ex(629, 4'd10, CR, CR, WR, WR, 2'b00, -1);
    ex(633, 4'd1,  CG, CR, WR, WR, 2'b00, -1);
    wait_r(581);
    emg_req = 1'b1;
    emg_dir = 1'b1;
    wait_r(599);
    emg_dir = 1'b0;
    wait_r(620);
    emg_req = 1'b0;

    // Same-axis emergency from NS_L; then preemption of an EW-road walk
    ex(713, 4'd2,  CY, CR, WR, WR, 2'b00, -1);
    ex(721, 4'd3,  CL, CR, WR, WR, 2'b00, -1);
    ex(730, 4'd3,  CL, CR, WR, WR, 2'b00, -1);
    ex(731, 4'd11, CG, CR, WR, WR, 2'b00, -1);
    ex(741, 4'd4,  CY, CR, WR, WR, 2'b00, -1);
    ex(749, 4'd5,  CR, CR, WR, WR, 2'b00, -1);
    ex(753, 4'd6,  CR, CG, WR, WR, 2'b00, -1);
    ex(760, 4'd6,  CR, CG, WR, WR, 2'b10, -1);
    ex(833, 4'd7,  CR, CY, WR, WR, 2'b10, -1);
    ex(893, 4'd1,  CG, CR, WR, WG, 2'b00, -1);
    ex(899, 4'd1,  CG, CR, WR, WG, 2'b00, -1);
    ex(900, 4'd11, CG, CR, WR, WR, 2'b00, -1);
    ex(902, 4'd11, CG, CR, WR, WR, 2'b01, -1);
    ex(906, 4'd4,  CY, CR, WR, WR, 2'b01, -1);
    ex(914, 4'd5,  CR, CR, WR, WR, 2'b01, -1);
    ex(918, 4'd6,  CR, CG, WG, WR, 2'b00, -1);
    ex(998, 4'd7,  CR, CY, WR, WR, 2'b00, -1);
    ex(1006, 4'd8, CR, CL, WR, WR, 2'b00, -1);
    wait_r(730);
    emg_req = 1'b1;
    emg_dir = 1'b0;
    wait_r(740);
    emg_req = 1'b0;
    wait_r(759);
    ped_req = 2'b10;
    wait_r(760);
    ped_req = 2'b00;
    wait_r(899);
    emg_req = 1'b1;
    emg_dir = 1'b0;
    wait_r(901);
    ped_req = 2'b01;
    wait_r(902);
    ped_req = 2'b00;
    wait_r(905);
    emg_req = 1'b0;

    // Async reset mid EW_L, then enable toggle with a pending EW-road request
    ex(1010, 4'd8, CR, CL, WR, WR, 2'b00, -1);
    ex(1011, 4'd0, CN, CN, WN, WN, 2'b00, 0);
    ex(1013, 4'd0, CN, CN, WN, WN, 2'b00, 0);
    ex(1014, 4'd1, CG, CR, WR, WR, 2'b00, 0);
    ex(1025, 4'd1, CG, CR, WR, WR, 2'b10, -1);
    ex(1031, 4'd0, CN, CN, WN, WN, 2'b10, 0);
    ex(1034, 4'd0, CN, CN, WN, WN, 2'b10, 0);
    ex(1035, 4'd1, CG, CR, WR, WG, 2'b00, 0);
    ex(1114, 4'd1, CG, CR, WR, WN, 2'b00, 1);
    ex(1115, 4'd2, CY, CR, WR, WR, 2'b00, 0);
    wait_r(1010);
    @(posedge clk);
    #1 reset_n = 1'b0;
    wait_r(1013);
    reset_n = 1'b1;
    wait_r(1024);
    ped_req = 2'b10;
    wait_r(1025);
    ped_req = 2'b00;
    wait_r(1030);
    enable = 1'b0;
    wait_r(1034);
    enable = 1'b1;
    wait_r(1115);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain got pending=%0d required pending=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_sched.md
# traffic_sched

Phase scheduler for a two-axis (NS/EW) signalised intersection. It divides the system clock into a tick and sequences car phases: green, yellow, protected left, yellow and all-red, alternating between the two axes. It latches pedestrian push-button requests, grants walk windows with a flashing clearance, and handles emergency-vehicle preemption. It drives the car-head and walker-head buses for the intersection directly.

## Interface
- TICK_DIV, 100: clk cycles per tick (≥2)
- T_GREEN, 20: green duration, ticks (≥ T_WALK+T_FLASH)
- T_YELLOW, 2: yellow duration, ticks
- T_LEFT, 10: protected-left duration, ticks
- T_ALLRED, 1: all-red duration, ticks
- T_WALK, 14: steady walk-green, ticks
- T_FLASH, 6: flashing walk clearance, ticks (even)
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- i_enable  in  1  run; low forces IDLE
- i_ped_req  in  2  button pulses/levels; [0] cross NS road, [1] cross EW road
- i_emg_req  in  1  emergency preemption request (level)
- i_emg_dir  in  1  axis to clear for emergency; 0=NS, 1=EW
- o_phase  out  4  current state code
- o_tick  out  1  one-cycle tick strobe
- o_ns_car, o_ew_car  out  4 each  car heads: RED 1000, YELLOW 0100, LEFT 0010, GREEN 0001, NONE 0000
- o_ns_walk, o_ew_walk  out  2 each  walk heads for crossing that road: RED 10, GREEN 01, NONE 00
- o_ped_pend  out  2  latched pending pedestrian requests

## Operation
- State codes: IDLE 0, NS_G 1, NS_Y1 2, NS_L 3, NS_Y2 4, AR_A 5, EW_G 6, EW_Y1 7, EW_L 8, EW_Y2 9, AR_B 10, EMG 11.
- Normal sequence: NS_G(T_GREEN) → NS_Y1(T_YELLOW) → NS_L(T_LEFT) → NS_Y2(T_YELLOW) → AR_A(T_ALLRED) → EW_G … → AR_B → NS_G.
- Car heads: the active axis shows GREEN, YELLOW or LEFT per state; the other axis shows RED; both axes are RED in AR_x and NONE in IDLE.
- Ped latch: i_ped_req[k] sets o_ped_pend[k]. The bit clears on the cycle its walk window starts.
- Walk window: NS-road walk (o_ns_walk) runs in EW_G if o_ped_pend[0]=1 at EW_G entry; EW-road walk mirrors this in NS_G with pend[1].
- Walk head pattern within the window, by tick index n from phase entry:
  - n < T_WALK: GREEN.
  - T_WALK ≤ n < T_WALK+T_FLASH: GREEN when (n−T_WALK) is even, NONE when odd.
  - Otherwise: RED.
- Walk heads are RED in all other running states and NONE in IDLE.
- A request arriving during its own window re-latches and is served next cycle round.
- Emergency request, first sampled high in a running state: latch r_emg_dir = i_emg_dir.
  - In x_G or x_L with x = dir: go to EMG next clk.
  - In x_G or x_L with x ≠ dir: go to x_Y2.
  - In yellow or AR states: finish the phase normally. Y1 under emergency goes to Y2 skip: Y1 → AR directly, no left.
  - At end of any AR with emergency active: go to EMG.
- EMG: dir axis GREEN, other axis RED, both walks RED.
  - An active walk window aborts to RED immediately when preemption starts.
  - i_emg_dir changes are ignored while in EMG.
  - i_emg_req low → dir axis Y2 → AR → other axis G, normal from there.
- Pending ped bits are kept across preemption.
- i_enable low: IDLE next clk, all heads NONE, timers cleared, pend kept.
- IDLE with i_enable high: NS_G next clk.

## Timing
- Reset (async): state IDLE, o_phase 0, all heads NONE, o_tick 0, pend 00, prescaler and phase timer 0, emergency latch clear.
- Prescaler counts 0..TICK_DIV−1. o_tick pulses for one cycle when it wraps.
- The prescaler and phase timer reset on every state change, so a D-tick phase lasts exactly D×TICK_DIV clk cycles.
- State advances on the clk edge where the tick completes tick D−1.
- Outputs decode the registered state and timers only. They change on the same edge as state, with no input-to-output combinational path.
- Full normal cycle with defaults: 70 ticks.
- Emergency entry from a same-axis G/L takes 1 clk. Entry from the other axis takes T_YELLOW+T_ALLRED ticks.
- Simultaneous ped request and window start: the bit clears and the window runs; the request counts as served.
- Emergency and end-of-phase on the same edge: the emergency rule wins.

## Test plan
- Reset release, then i_enable=1, TICK_DIV=4: NS_G at clk 1; NS_Y1 at clk 81; AR_A→EW_G at clk 141; back to NS_G at clk 281.
- Pulse i_ped_req[0] during NS_G:
  - pend=01 until EW_G entry.
  - o_ns_walk GREEN for 56 clk, then GREEN/NONE alternating every 4 clk for 24 clk, then RED.
  - No walk on the next round without a new request.
- No requests for a full cycle: both walk heads stay RED; pend stays 00.
- i_emg_req=1, dir=1 at NS_G tick 5: NS_Y2 (2 ticks) → AR_A (1 tick) → EMG with EW GREEN, NS RED. Drop the request: EW_Y2 → AR_B → NS_G.
- i_emg_req=1, dir=0 during NS_L with the NS walk inactive: EMG next clk with NS GREEN. Emergency during an active EW-road walk: o_ew_walk goes RED on the transition edge.
- Async reset_n low mid-EW_L: all outputs NONE and phase 0 immediately, without waiting for a clk edge. i_enable toggled low then high mid-cycle: IDLE, then NS_G with a fresh timer.
